rf_mp: RTL and testbench

//  Parametrised multi-port register file; successor to the single-write, 2-read, 32x32 RF.

---
 rtl/rf_mp.sv | 115 +++++++++++
 tb/tb_rf_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_mp.sv
// Multi-port register file: NR combinational read ports, two write ports (port 1 wins on conflict), clear sweep.
// Latency: 0-cycle reads, writes land on the next edge; no backpressure, writes are dropped while ready_o=0.
module rf_mp #(
   parameter int DW      = 32,
   parameter int DEPTH   = 32,
   parameter int AW      = 5,
   parameter int NR      = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   output logic             ready_o,
   input  logic [NR*AW-1:0] ra_i,
   output logic [NR*DW-1:0] rd_o,
   input  logic             we0_i,
   input  logic [AW-1:0]    wa0_i,
   input  logic [DW-1:0]    wd0_i,
   input  logic             we1_i,
   input  logic [AW-1:0]    wa1_i,
   input  logic [DW-1:0]    wd1_i
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic            we0_eff, we1_eff;
   logic [AW-1:0]   ra_k;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            if (clr_i) begin
               clr_cnt_d = '0;
            end else if (clr_cnt_q == AW'(DEPTH - 1)) begin
               state_d   = READY;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         READY: begin
            if (clr_i) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign ready_o = (state_q == READY);

   // Enables are filtered once so commit and bypass can never disagree.
   assign we0_eff = ready_o && we0_i && !((ZERO_R0 != 0) && (wa0_i == '0));
   assign we1_eff = ready_o && we1_i && !((ZERO_R0 != 0) && (wa1_i == '0));

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (!ready_o) begin
         mem_d[clr_cnt_q] = '0;
      end else begin
         if (we0_eff) mem_d[wa0_i] = wd0_i;
         if (we1_eff) mem_d[wa1_i] = wd1_i;
      end
   end

   // Array is deliberately not reset; the sweep zeroes it before ready_o rises.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      rd_o = '0;
      ra_k = '0;
      for (int k = 0; k < NR; k++) begin
         ra_k = ra_i[k*AW +: AW];
         if (!ready_o) begin
            rd_o[k*DW +: DW] = '0;
         end else if ((ZERO_R0 != 0) && (ra_k == '0)) begin
            rd_o[k*DW +: DW] = '0;
         end else if ((BYPASS != 0) && we1_eff && (wa1_i == ra_k)) begin
            rd_o[k*DW +: DW] = wd1_i;
         end else if ((BYPASS != 0) && we0_eff && (wa0_i == ra_k)) begin
            rd_o[k*DW +: DW] = wd0_i;
         end else begin
            rd_o[k*DW +: DW] = mem_q[ra_k];
         end
      end
   end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: bypass/zero-r0 instance and plain instance driven in lockstep against an array model.
module tb_rf_mp;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;

   logic             clk;
   logic             rst;
   logic             clr_i;
   logic             rdy_a, rdy_b;
   logic [NR*AW-1:0] ra_i;
   logic [NR*DW-1:0] rd_a, rd_b;
   logic             we0, we1;
   logic [AW-1:0]    wa0, wa1;
   logic [DW-1:0]    wd0, wd1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] ref_a [DEPTH];
   logic [DW-1:0] ref_b [DEPTH];
   bit            ref_rdy;
   int            sweep_left;
   int            edges;

   rf_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .BYPASS(1), .ZERO_R0(1)) u_dut (
      .clk(clk), .rst(rst), .clr_i(clr_i), .ready_o(rdy_a), .ra_i(ra_i), .rd_o(rd_a),
      .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1));

   rf_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .BYPASS(0), .ZERO_R0(0)) u_dut_plain (
      .clk(clk), .rst(rst), .clr_i(clr_i), .ready_o(rdy_b), .ra_i(ra_i), .rd_o(rd_b),
      .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Any clear makes the whole array read as zero once ready, so zero it up front.
   task automatic model_clear();
      ref_rdy    = 1'b0;
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         ref_a[i] = '0;
         ref_b[i] = '0;
      end
   endtask

   task automatic model_edge();
      if (ref_rdy) begin
         if (we0 && wa0 != 0) ref_a[wa0] = wd0;
         if (we1 && wa1 != 0) ref_a[wa1] = wd1;
         if (we0) ref_b[wa0] = wd0;
         if (we1) ref_b[wa1] = wd1;
         if (clr_i) model_clear();
      end else if (clr_i) begin
         model_clear();
      end else begin
         sweep_left--;
         if (sweep_left == 0) ref_rdy = 1'b1;
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input bit plain, input logic [AW-1:0] ra);
      if (!ref_rdy) return '0;
      if (!plain && ra == 0) return '0;
      if (!plain && we1 && wa1 == ra) return wd1;
      if (!plain && we0 && wa0 == ra) return wd0;
      return plain ? ref_b[ra] : ref_a[ra];
   endfunction

   task automatic check_outputs();
      chk("ready_a", {31'd0, rdy_a}, {31'd0, ref_rdy});
      chk("ready_b", {31'd0, rdy_b}, {31'd0, ref_rdy});
      for (int k = 0; k < NR; k++) begin
         chk($sformatf("rd_a%0d", k), rd_a[k*DW +: DW], exp_rd(1'b0, ra_i[k*AW +: AW]));
         chk($sformatf("rd_b%0d", k), rd_b[k*DW +: DW], exp_rd(1'b1, ra_i[k*AW +: AW]));
      end
   endtask

   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we0   = 1'b0;
      we1   = 1'b0;
      clr_i = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (rdy_a !== 1'b1 && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      rst = 1'b1; clr_i = 1'b0; ra_i = '0;
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      model_clear();
      #22;
      rst = 1'b0;
      #1;
      model_clear();
      check_outputs();

      // Reset sweep with writes attempted before ready
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
      wait_ready(edges);
      chk("sweep_len_reset", edges, 32);
      idle();
      ra_i = {5'd0, 5'd5};
      #1;
      chk("r5_dropped", rd_a[31:0], 32'h0);
      step();

      // Dual write, then read back
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h12345678;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hCAFEF00D;
      step();
      idle();
      ra_i = {5'd7, 5'd3};
      #1;
      chk("r3_read", rd_a[31:0], 32'h12345678);
      chk("r7_read", rd_a[63:32], 32'hCAFEF00D);
      step();

      // Conflict on r9, port 1 wins; bypass only on the bypass instance
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1;
      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2;
      ra_i = {5'd0, 5'd9};
      #1;
      chk("byp_conflict", rd_a[31:0], 32'h2);
      chk("nobyp_old", rd_b[31:0], 32'h0);
      step();
      idle();
      #1;
      chk("r9_stored_a", rd_a[31:0], 32'h2);
      chk("r9_stored_b", rd_b[31:0], 32'h2);
      step();

      // Zero register
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
      ra_i = {5'd0, 5'd0};
      #1;
      chk("r0_bypass_zero", rd_a[31:0], 32'h0);
      step();
      idle();
      #1;
      chk("r0_zero", rd_a[31:0], 32'h0);
      chk("r0_plain", rd_b[31:0], 32'hFFFFFFFF);
      step();

      // Randomized traffic with rare clear requests
      for (int n = 0; n < 400; n++) begin
         we0   = 1'($urandom_range(0, 1));
         we1   = 1'($urandom_range(0, 1));
         wa0   = 5'($urandom_range(0, 7));
         wa1   = 5'($urandom_range(0, 7));
         wd0   = $urandom;
         wd1   = $urandom;
         ra_i  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         clr_i = ($urandom_range(0, 59) == 0);
         step();
      end
      idle();
      wait_ready(edges);

      // Fill, clear, re-clear at sweep step 10
      for (int i = 1; i < DEPTH; i += 2) begin
         we0 = 1'b1; wa0 = 5'(i);     wd0 = $urandom | 32'h1;
         we1 = (i + 1 < DEPTH); wa1 = 5'(i + 1); wd1 = $urandom | 32'h1;
         step();
      end
      idle();
      ra_i = {5'd31, 5'd1};
      #1;
      chk("r1_filled", {31'd0, rd_a[31:0] != 0}, 32'h1);
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      for (int i = 0; i < 9; i++) step();
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      wait_ready(edges);
      chk("sweep_len_restart", edges, 32);
      for (int i = 0; i < DEPTH; i += 2) begin
         ra_i = {5'(i + 1), 5'(i)};
         #1;
         chk("cleared_a", rd_a[31:0] | rd_a[63:32], 32'h0);
         chk("cleared_b", rd_b[31:0] | rd_b[63:32], 32'h0);
         step();
      end

      // Async reset in the middle of a sweep
      we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hA5A5A5A5;
      step();
      idle();
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      chk("async_rst_ready", {31'd0, rdy_a}, 32'h0);
      check_outputs();
      #2;
      rst = 1'b0;
      wait_ready(edges);
      chk("sweep_len_async", edges, 32);
      ra_i = {5'd0, 5'd12};
      #1;
      chk("r12_cleared", rd_a[31:0], 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
